// File: rtl/sc_types_pkg.sv
// Shared types for the charging-port scheduler: scheduler states, grid codes, budget map.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package sc_types_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2,
    S_HOLD = 2'd3
  } sched_state_t;

  typedef logic [1:0] grid_state_t;

  localparam grid_state_t GRID_NORMAL   = 2'd0;
  localparam grid_state_t GRID_UNSTABLE = 2'd1;
  localparam grid_state_t GRID_CRITICAL = 2'd2;

  // Concurrent-grant budget allowed by the grid; code 3 is handled like CRITICAL.
  function automatic int grid_budget(input grid_state_t g, input int max_normal,
                                     input int max_unstable);
    case (g)
      GRID_NORMAL:   return max_normal;
      GRID_UNSTABLE: return max_unstable;
      default:       return 0;
    endcase
  endfunction

endpackage

// File: rtl/sc_rr_pick.sv
// Picks the first k set bits of mask in round-robin order starting at ptr (or the reverse order).
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module sc_rr_pick #(
  parameter int N       = 4,
  parameter bit REVERSE = 1'b0
) (
  input  logic [N-1:0]           mask,
  input  logic [$clog2(N)-1:0]   ptr,
  input  logic [$clog2(N+1)-1:0] k,
  output logic [N-1:0]           pick,
  output logic [$clog2(N)-1:0]   last
);

  localparam int PW = $clog2(N);
  localparam int KW = $clog2(N+1);

  logic [KW-1:0] taken;
  logic [PW-1:0] idx;

  // Walk the ring once; reverse order visits ptr-1 first, i.e. the port farthest from ptr.
  always_comb begin
    pick  = '0;
    last  = '0;
    taken = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (REVERSE) idx = PW'((int'(ptr) + N - 1 - i) % N);
      else         idx = PW'((int'(ptr) + i) % N);
      if (mask[idx] && (taken < k)) begin
        pick[idx] = 1'b1;
        last      = idx;
        taken     = taken + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sc_port_scheduler.sv
// Shares the grid power budget between charging ports with round-robin time slices.
// Latency: every output is registered, one cycle after any input change.
// Backpressure: none; grants drop as soon as req falls or the budget shrinks.
module sc_port_scheduler
  import sc_types_pkg::*;
#(
  parameter int N_PORTS          = 4,
  parameter int MAX_ACT_NORMAL   = 2,
  parameter int MAX_ACT_UNSTABLE = 1,
  parameter int SLOT_CYCLES      = 1000,
  parameter int GAP_CYCLES       = 16,
  parameter int HOLD_CYCLES      = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   grid_state,
  input  logic [N_PORTS-1:0]           req,
  output logic [N_PORTS-1:0]           grant,
  output logic [$clog2(N_PORTS+1)-1:0] active_count,
  output logic [1:0]                   sched_state,
  output logic                         fault
);

  localparam int PW = $clog2(N_PORTS);
  localparam int CW = $clog2(N_PORTS+1);
  localparam int SW = $clog2(SLOT_CYCLES+1);
  localparam int GW = $clog2(GAP_CYCLES+1);
  localparam int HW = $clog2(HOLD_CYCLES+1);

  sched_state_t        state_q, state_n;
  logic [N_PORTS-1:0]  grant_q, grant_n;
  logic [CW-1:0]       count_q;
  logic                fault_q;
  logic [PW-1:0]       ptr_q, ptr_n;
  logic [SW-1:0]       slot_q, slot_n;
  logic [GW-1:0]       gap_q, gap_n;
  logic [HW-1:0]       hold_q, hold_n;

  logic [CW-1:0]       budget, kept_cnt, shed_k, fill_k;
  logic [N_PORTS-1:0]  kept, shed_pick, fill_pick, cand;
  logic [PW-1:0]       shed_last, fill_last, hi_idx, idx;
  logic                critical;

  assign budget   = CW'(grid_budget(grid_state, MAX_ACT_NORMAL, MAX_ACT_UNSTABLE));
  assign critical = grid_state[1];
  assign kept     = grant_q & req;
  assign kept_cnt = CW'($countones(kept));
  assign shed_k   = (kept_cnt > budget) ? kept_cnt - budget : '0;
  assign fill_k   = (kept_cnt < budget) ? budget - kept_cnt : '0;
  // grant is zero outside S_RUN, so the same fill path also serves fresh allocation.
  assign cand     = (kept & ~shed_pick) | fill_pick;

  sc_rr_pick #(.N(N_PORTS), .REVERSE(1'b1)) u_shed (
    .mask(kept), .ptr(ptr_q), .k(shed_k), .pick(shed_pick), .last(shed_last)
  );

  sc_rr_pick #(.N(N_PORTS), .REVERSE(1'b0)) u_fill (
    .mask(req & ~kept), .ptr(ptr_q), .k(fill_k), .pick(fill_pick), .last(fill_last)
  );

  // Last candidate grant in RR order; the next slot starts just after it.
  always_comb begin
    hi_idx = ptr_q;
    idx    = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = PW'((int'(ptr_q) + i) % N_PORTS);
      if (cand[idx]) hi_idx = idx;
    end
  end

  // Next-state and next-grant logic; CRITICAL overrides everything else.
  always_comb begin
    state_n = state_q;
    grant_n = grant_q;
    ptr_n   = ptr_q;
    slot_n  = slot_q;
    gap_n   = gap_q;
    hold_n  = hold_q;
    if (critical) begin
      state_n = S_HOLD;
      grant_n = '0;
      hold_n  = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          grant_n = '0;
          if (grid_state == GRID_NORMAL) begin
            if (hold_q == HW'(HOLD_CYCLES-1)) begin
              state_n = S_IDLE;
              hold_n  = '0;
            end else begin
              hold_n = hold_q + 1'b1;
            end
          end else begin
            hold_n = '0;
          end
        end
        S_IDLE: begin
          grant_n = '0;
          if (cand != '0) begin
            grant_n = cand;
            state_n = S_RUN;
            slot_n  = '0;
          end
        end
        S_GAP: begin
          grant_n = '0;
          if (gap_q == GW'(GAP_CYCLES-1)) begin
            gap_n   = '0;
            slot_n  = '0;
            grant_n = cand;
            state_n = (cand != '0) ? S_RUN : S_IDLE;
          end else begin
            gap_n = gap_q + 1'b1;
          end
        end
        S_RUN: begin
          if (req == '0) begin
            state_n = S_IDLE;
            grant_n = '0;
            slot_n  = '0;
          end else if (slot_q == SW'(SLOT_CYCLES-1)) begin
            slot_n = '0;
            if ((req & ~cand) != '0) begin
              if (cand != '0) ptr_n = PW'((int'(hi_idx) + 1) % N_PORTS);
              grant_n = '0;
              gap_n   = '0;
              state_n = S_GAP;
            end else begin
              grant_n = cand;
            end
          end else begin
            slot_n  = slot_q + 1'b1;
            grant_n = cand;
          end
        end
        default: begin
          state_n = S_HOLD;
          grant_n = '0;
          hold_n  = '0;
        end
      endcase
    end
  end

  // State registers; reset clears all scheduling history including the RR pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      count_q <= '0;
      fault_q <= 1'b0;
      ptr_q   <= '0;
      slot_q  <= '0;
      gap_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_n;
      grant_q <= grant_n;
      count_q <= CW'($countones(grant_n));
      fault_q <= (state_n == S_HOLD);
      ptr_q   <= ptr_n;
      slot_q  <= slot_n;
      gap_q   <= gap_n;
      hold_q  <= hold_n;
    end
  end

  assign grant        = grant_q;
  assign active_count = count_q;
  assign sched_state  = state_q;
  assign fault        = fault_q;

endmodule
